// File: rtl/cond_branch_unit.sv
// cond_branch_unit: NZCV flag register plus conditional-branch resolver that
// stalls a request until every issued compare has written back its flags.
module cond_branch_unit #(
    parameter int CNT_W = 3,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      flag_in,
    input  logic            flag_we,
    input  logic            flag_pend,
    output logic            pend_full,
    output logic [3:0]      flag_out,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_cond,
    input  logic [PC_W-1:0] req_pc,
    input  logic [PC_W-1:0] req_off,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_taken,
    output logic [PC_W-1:0] resp_target
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e          state_q, state_d;
    logic [3:0]      flag_q, flag_d, cond_q, cond_d, eff_flags;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0] pc_q, pc_d, off_q, off_d, target_q, target_d;
    logic            taken_q, taken_d;
    logic            n, z, c, v;
    logic [15:0]     truth;

    assign pend_full   = cnt_q == CNT_MAX;
    assign flag_out    = flag_q;
    assign req_ready   = state_q == IDLE && !rst;
    assign resp_valid  = state_q == RESP;
    assign resp_taken  = taken_q;
    assign resp_target = target_q;

    always_comb begin
        eff_flags = flag_we ? flag_in : flag_q;
        {n, z, c, v} = eff_flags;
        // bit i is the outcome of condition code i
        truth = {1'b0, 1'b1, z | (n ^ v), !z & !(n ^ v), n ^ v, !(n ^ v), !c | z, c & !z,
                 !v, v, !n, n, !c, c, !z, z};
        flag_d = eff_flags;
        cnt_d = (flag_pend && !flag_we && !pend_full) ? cnt_q + CNT_W'(1) :
                (flag_we && !flag_pend && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        state_d  = state_q;
        cond_d   = cond_q;
        pc_d     = pc_q;
        off_d    = off_q;
        taken_d  = taken_q;
        target_d = target_q;
        if (state_q == IDLE && req_valid) begin
            state_d = WAIT;
            cond_d  = req_cond;
            pc_d    = req_pc;
            off_d   = req_off;
        end else if (state_q == WAIT && cnt_d == '0) begin
            state_d  = RESP;
            taken_d  = truth[cond_q];
            target_d = pc_q + (truth[cond_q] ? off_q : PC_W'(4));
        end else if (state_q == RESP && resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            flag_q   <= '0;
            cnt_q    <= '0;
            cond_q   <= '0;
            pc_q     <= '0;
            off_q    <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            flag_q   <= flag_d;
            cnt_q    <= cnt_d;
            cond_q   <= cond_d;
            pc_q     <= pc_d;
            off_q    <= off_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end
endmodule

// File: tb/tb_cond_branch_unit.sv
// tb_cond_branch_unit: scoreboard bench for cond_branch_unit; expected
// resolutions are queued at request time and compared on resp_valid.
module tb_cond_branch_unit;
    localparam int CNT_W = 3;
    localparam int PC_W  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      flag_in = '0;
    logic            flag_we = 1'b0;
    logic            flag_pend = 1'b0;
    logic            pend_full;
    logic [3:0]      flag_out;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [3:0]      req_cond = '0;
    logic [PC_W-1:0] req_pc = '0;
    logic [PC_W-1:0] req_off = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic            resp_taken;
    logic [PC_W-1:0] resp_target;

    int n_chk = 0;
    int n_pass = 0;
    int waited;
    logic [PC_W:0] sb[$];
    logic [3:0] mflags = '0;

    cond_branch_unit #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flag_in(flag_in), .flag_we(flag_we), .flag_pend(flag_pend),
        .pend_full(pend_full), .flag_out(flag_out), .req_valid(req_valid), .req_ready(req_ready),
        .req_cond(req_cond), .req_pc(req_pc), .req_off(req_off), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_taken(resp_taken), .resp_target(resp_target)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    endtask

    function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cc)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fn;
            4'd5:  return !fn;
            4'd6:  return fv;
            4'd7:  return !fv;
            4'd8:  return fc && !fz;
            4'd9:  return !fc || fz;
            4'd10: return fn == fv;
            4'd11: return fn != fv;
            4'd12: return !fz && (fn == fv);
            4'd13: return fz || (fn != fv);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [3:0] cc, input logic [PC_W-1:0] pc,
                            input logic [PC_W-1:0] off, input logic [3:0] f);
        logic t;
        logic [PC_W-1:0] tgt;
        t = model_cond(cc, f);
        tgt = t ? pc + off : pc + 32'd4;
        sb.push_back({t, tgt});
    endtask

    task automatic send(input logic [3:0] cc, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] off);
        req_valid = 1'b1;
        req_cond = cc;
        req_pc = pc;
        req_off = off;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic write_flags(input logic [3:0] f);
        flag_in = f;
        flag_we = 1'b1;
        tick();
        flag_we = 1'b0;
        mflags = f;
    endtask

    task automatic get_resp(input string tag, input int max, output int w);
        logic [PC_W:0] e;
        w = 0;
        while (!resp_valid && w < max) begin
            tick();
            w++;
        end
        if (!resp_valid) begin
            check({tag, "_timeout"}, 64'(resp_valid), 64'd1);
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_unexpected_resp"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_taken"}, 64'(resp_taken), 64'(e[PC_W]));
            check({tag, "_target"}, 64'(resp_target), 64'(e[PC_W-1:0]));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        tick();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_flag_out", 64'(flag_out), 64'd0);
        check("rst_pend_full", 64'(pend_full), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_taken", 64'(resp_taken), 64'd0);
        check("rst_resp_target", 64'(resp_target), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        write_flags(4'b0100);
        check("flag_load", 64'(flag_out), 64'(4'b0100));
        push_exp(4'd0, 32'h100, 32'h20, mflags);
        send(4'd0, 32'h100, 32'h20);
        get_resp("eq", 10, waited);
        check("eq_latency", 64'(waited), 64'd1);
        push_exp(4'd1, 32'h100, 32'h20, mflags);
        send(4'd1, 32'h100, 32'h20);
        get_resp("ne", 10, waited);

        flag_pend = 1'b1;
        tick();
        flag_pend = 1'b0;
        push_exp(4'd10, 32'h300, 32'h40, 4'b1000);
        send(4'd10, 32'h300, 32'h40);
        for (int i = 0; i < 4; i++) begin
            check("pend_stall", 64'(resp_valid), 64'd0);
            tick();
        end
        flag_in = 4'b1000;
        flag_we = 1'b1;
        check("pend_stall_we_cycle", 64'(resp_valid), 64'd0);
        tick();
        flag_we = 1'b0;
        mflags = 4'b1000;
        check("pend_release", 64'(resp_valid), 64'd1);
        get_resp("ge_pend", 0, waited);

        for (int f = 0; f < 16; f++) begin
            write_flags(4'(f));
            for (int cc = 0; cc < 16; cc++) begin
                push_exp(4'(cc), 32'hFFFF_FFFC, 32'd8, mflags);
                send(4'(cc), 32'hFFFF_FFFC, 32'd8);
                get_resp($sformatf("sweep_f%0d_c%0d", f, cc), 10, waited);
            end
        end

        write_flags(4'b0100);
        push_exp(4'd0, 32'h200, 32'hFFFF_FFF0, mflags);
        send(4'd0, 32'h200, 32'hFFFF_FFF0);
        waited = 0;
        while (!resp_valid && waited < 10) begin
            tick();
            waited++;
        end
        check("hold_valid", 64'(resp_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            flag_in = 4'(i);
            flag_we = i[0];
            tick();
            check("hold_taken", 64'(resp_taken), 64'd1);
            check("hold_target", 64'(resp_target), 64'h1F0);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_valid_held", 64'(resp_valid), 64'd1);
        end
        flag_we = 1'b0;
        get_resp("hold", 0, waited);
        check("hold_ready_after", 64'(req_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            flag_pend = 1'b1;
            tick();
            check($sformatf("pend_full_after_%0d", i + 1), 64'(pend_full), 64'(i >= 6));
        end
        flag_pend = 1'b1;
        flag_in = 4'b0011;
        flag_we = 1'b1;
        tick();
        flag_pend = 1'b0;
        flag_we = 1'b0;
        check("both_flags", 64'(flag_out), 64'(4'b0011));
        check("both_full", 64'(pend_full), 64'd1);
        for (int i = 0; i < 6; i++) write_flags(4'b0011);
        check("dec_not_full", 64'(pend_full), 64'd0);
        push_exp(4'd14, 32'h400, 32'h10, mflags);
        send(4'd14, 32'h400, 32'h10);
        for (int i = 0; i < 3; i++) begin
            check("count1_stall", 64'(resp_valid), 64'd0);
            tick();
        end
        write_flags(4'b0001);
        get_resp("count1_release", 0, waited);
        write_flags(4'b1001);
        check("we_at_zero_flags", 64'(flag_out), 64'(4'b1001));
        check("we_at_zero_full", 64'(pend_full), 64'd0);
        push_exp(4'd6, 32'h500, 32'h8, mflags);
        send(4'd6, 32'h500, 32'h8);
        get_resp("count0", 10, waited);
        check("count0_latency", 64'(waited), 64'd1);

        flag_pend = 1'b1;
        tick();
        tick();
        flag_pend = 1'b0;
        send(4'd14, 32'h600, 32'h4);
        tick();
        check("wait_before_rst", 64'(resp_valid), 64'd0);
        rst = 1'b1;
        tick();
        check("rst_mid_valid", 64'(resp_valid), 64'd0);
        check("rst_mid_flags", 64'(flag_out), 64'd0);
        check("rst_mid_full", 64'(pend_full), 64'd0);
        rst = 1'b0;
        mflags = '0;
        tick();
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) write_flags(4'b1111);
            else tick();
            check("rst_no_resp", 64'(resp_valid), 64'd0);
        end
        push_exp(4'd4, 32'h700, 32'h30, mflags);
        send(4'd4, 32'h700, 32'h30);
        get_resp("post_rst", 10, waited);
        check("post_rst_latency", 64'(waited), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
